// File: rtl/mtr_diag_rd_if.sv
// Diagnostic read path signal bundle between a requester/meter-board side (master)
// and the mtr_diag_rd_seq sequencer (slave).
interface mtr_diag_rd_if;
  logic        rd_req_h;
  logic [2:0]  rd_func_h;
  logic        rd_busy_h;
  logic        rd_done_h;
  logic [17:0] rd_data_h;
  logic        rd_err_h;
  logic        ctl3_diag_rd_func_11x_l;
  logic        diag_04_b_h;
  logic        diag_05_b_h;
  logic        diag_06_b_h;
  logic [17:0] ebus_d_e_h;

  modport master (
    output rd_req_h, rd_func_h, ebus_d_e_h,
    input  rd_busy_h, rd_done_h, rd_data_h, rd_err_h,
           ctl3_diag_rd_func_11x_l, diag_04_b_h, diag_05_b_h, diag_06_b_h
  );

  modport slave (
    input  rd_req_h, rd_func_h, ebus_d_e_h,
    output rd_busy_h, rd_done_h, rd_data_h, rd_err_h,
           ctl3_diag_rd_func_11x_l, diag_04_b_h, diag_05_b_h, diag_06_b_h
  );
endinterface

// File: rtl/mtr_diag_rd_seq.sv
// Meter-board diagnostic read sequencer: drives DIAG 04-06 and the diag read strobe,
// captures EBUS D18-D35. Define MTR_RD_STABLE_EN to require two equal captures.
//
// state  | meaning
// IDLE   | waiting for rd_req_h, strobe high, DIAG lines 0
// SETUP  | DIAG lines driven from latched code, strobe high
// STROBE | strobe low, EBUS captured on the last cycle
// GAP    | strobe high between repeat reads (MTR_RD_STABLE_EN only)
// DONE   | one-cycle rd_done_h pulse, DIAG lines 0
module mtr_diag_rd_seq #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic         clk_mtr_h,
  input  logic         mr_reset_l,
  mtr_diag_rd_if.slave rd_if
);

  localparam int unsigned CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || MAX_RETRY < 1) begin : g_param_check
    $error("mtr_diag_rd_seq: SETUP_CYC, STROBE_CYC and MAX_RETRY must all be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
`ifdef MTR_RD_STABLE_EN
    GAP,
`endif
    DONE
  } state_t;

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  diag_q;
  logic        strobe_l_q;
  logic        busy_q;
  logic        done_q;
  logic [17:0] data_q;

`ifdef MTR_RD_STABLE_EN
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q;
  logic [17:0]      cmp_q;
  logic             cmp_vld_q;
  logic             err_q;
`endif

  always_ff @(posedge clk_mtr_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      diag_q     <= '0;
      strobe_l_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
`ifdef MTR_RD_STABLE_EN
      retry_q    <= '0;
      cmp_q      <= '0;
      cmp_vld_q  <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_if.rd_req_h) begin
            state_q <= SETUP;
            cnt_q   <= CNT_W'(SETUP_CYC - 1);
            diag_q  <= rd_if.rd_func_h;
            busy_q  <= 1'b1;
`ifdef MTR_RD_STABLE_EN
            retry_q   <= '0;
            cmp_vld_q <= 1'b0;
`endif
          end
        end

        SETUP: begin
          if (cnt_q == '0) begin
            state_q    <= STROBE;
            strobe_l_q <= 1'b0;
            cnt_q      <= CNT_W'(STROBE_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            strobe_l_q <= 1'b1;
`ifdef MTR_RD_STABLE_EN
            // Compare against the previous capture; a mismatch means EBUS was still settling.
            if (!cmp_vld_q) begin
              cmp_q     <= rd_if.ebus_d_e_h;
              cmp_vld_q <= 1'b1;
              state_q   <= GAP;
            end else if (rd_if.ebus_d_e_h == cmp_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              data_q  <= rd_if.ebus_d_e_h;
              diag_q  <= '0;
              err_q   <= 1'b0;
            end else if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              data_q  <= rd_if.ebus_d_e_h;
              diag_q  <= '0;
              err_q   <= 1'b1;
            end else begin
              retry_q <= retry_q + 1'b1;
              cmp_q   <= rd_if.ebus_d_e_h;
              state_q <= GAP;
            end
`else
            state_q <= DONE;
            done_q  <= 1'b1;
            data_q  <= rd_if.ebus_d_e_h;
            diag_q  <= '0;
`endif
          end
        end

`ifdef MTR_RD_STABLE_EN
        GAP: begin
          state_q    <= STROBE;
          strobe_l_q <= 1'b0;
          cnt_q      <= CNT_W'(STROBE_CYC - 1);
        end
`endif

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifdef MTR_RD_STABLE_EN
          err_q   <= 1'b0;
`endif
        end

        default: begin
          state_q    <= IDLE;
          strobe_l_q <= 1'b1;
          diag_q     <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_if.rd_busy_h               = busy_q;
  assign rd_if.rd_done_h               = done_q;
  assign rd_if.rd_data_h               = data_q;
  assign rd_if.ctl3_diag_rd_func_11x_l = strobe_l_q;
  assign rd_if.diag_04_b_h             = diag_q[2];
  assign rd_if.diag_05_b_h             = diag_q[1];
  assign rd_if.diag_06_b_h             = diag_q[0];
`ifdef MTR_RD_STABLE_EN
  assign rd_if.rd_err_h                = err_q;
`else
  assign rd_if.rd_err_h                = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_diag_rd_seq.sv
// Self-checking bench for mtr_diag_rd_seq: cycle-exact sequences, a vector table,
// and a done-pulse scoreboard. Stable-read cases build only with MTR_RD_STABLE_EN.
module tb_mtr_diag_rd_seq;
  localparam int S = 2;
  localparam int T = 4;
`ifdef MTR_RD_STABLE_EN
  localparam bit STABLE = 1'b1;
  localparam int LAT    = 2 + S + 2 * T;
`else
  localparam bit STABLE = 1'b0;
  localparam int LAT    = 1 + S + T;
`endif

  logic clk_mtr_h  = 1'b0;
  logic mr_reset_l = 1'b0;
  always #5 clk_mtr_h = ~clk_mtr_h;

  mtr_diag_rd_if rd_if();

  mtr_diag_rd_seq #(.SETUP_CYC(S), .STROBE_CYC(T), .MAX_RETRY(3)) dut (
    .clk_mtr_h  (clk_mtr_h),
    .mr_reset_l (mr_reset_l),
    .rd_if      (rd_if.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_mtr_h);
    #1;
  endtask

  function automatic logic [2:0] diag_now();
    return {rd_if.diag_04_b_h, rd_if.diag_05_b_h, rd_if.diag_06_b_h};
  endfunction

  function automatic logic exp_strobe_l(input int c);
    logic low;
    low = (c >= S + 1 && c <= S + T) || (STABLE && c >= S + T + 2 && c <= S + 2 * T + 1);
    return ~low;
  endfunction

  // Scoreboard: expected {data, err} pushed on request, popped on each done pulse.
  typedef struct packed {logic [17:0] data; logic err;} exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge clk_mtr_h) begin
    if (mr_reset_l && rd_if.rd_done_h === 1'b1) begin
      chk("sb_done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        chk("sb_data", 32'(rd_if.rd_data_h), 32'(sb_e.data));
        chk("sb_err", 32'(rd_if.rd_err_h), 32'(sb_e.err));
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (rd_if.rd_busy_h === 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(rd_if.rd_busy_h), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  func;
    logic [17:0] ebus;
    logic [17:0] exp_data;
    logic [2:0]  exp_diag;
  } vec_t;
  vec_t vecs[5];

`ifdef MTR_RD_STABLE_EN
  // Changes ebus on every falling strobe; returns the done cycle and strobe count.
  task automatic run_pat(input logic [17:0] p0, input logic [17:0] p1, input bit toggle,
                         output int done_c, output int n_strobe);
    logic prev;
    rd_if.rd_func_h  = 3'b011;
    rd_if.ebus_d_e_h = p0;
    rd_if.rd_req_h   = 1'b1;
    step();
    rd_if.rd_req_h = 1'b0;
    prev     = 1'b1;
    n_strobe = 0;
    done_c   = -1;
    for (int c = 1; c <= 60; c++) begin
      if (rd_if.ctl3_diag_rd_func_11x_l === 1'b0 && prev === 1'b1) begin
        n_strobe++;
        if (n_strobe == 1)  rd_if.ebus_d_e_h = p0;
        else if (toggle)    rd_if.ebus_d_e_h = (n_strobe % 2 == 1) ? p0 : p1;
        else                rd_if.ebus_d_e_h = p1;
      end
      if (rd_if.rd_done_h === 1'b1 && done_c < 0) done_c = c;
      prev = rd_if.ctl3_diag_rd_func_11x_l;
      step();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int done_c;
    int n_strobe;

    vecs[0] = '{3'b000, 18'h00000, 18'h00000, 3'b000};
    vecs[1] = '{3'b111, 18'h3FFFF, 18'h3FFFF, 3'b111};
    vecs[2] = '{3'b100, 18'h20001, 18'h20001, 3'b100};
    vecs[3] = '{3'b010, 18'h1FFFE, 18'h1FFFE, 3'b010};
    vecs[4] = '{3'b001, 18'h0F0F0, 18'h0F0F0, 3'b001};

    rd_if.rd_req_h   = 1'b0;
    rd_if.rd_func_h  = 3'b000;
    rd_if.ebus_d_e_h = 18'h0;
    step(); step();
    chk("rst_strobe", 32'(rd_if.ctl3_diag_rd_func_11x_l), 32'd1);
    chk("rst_busy",   32'(rd_if.rd_busy_h), 32'd0);
    chk("rst_done",   32'(rd_if.rd_done_h), 32'd0);
    chk("rst_err",    32'(rd_if.rd_err_h),  32'd0);
    chk("rst_data",   32'(rd_if.rd_data_h), 32'd0);
    chk("rst_diag",   32'(diag_now()),      32'd0);
    @(negedge clk_mtr_h);
    mr_reset_l = 1'b1;
    step();

    // Cycle-exact single read
    rd_if.rd_func_h  = 3'b101;
    rd_if.ebus_d_e_h = 18'h2A5A5;
    rd_if.rd_req_h   = 1'b1;
    sb_q.push_back('{18'h2A5A5, 1'b0});
    step();
    rd_if.rd_req_h = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      chk($sformatf("t1_strobe_c%0d", c), 32'(rd_if.ctl3_diag_rd_func_11x_l), 32'(exp_strobe_l(c)));
      chk($sformatf("t1_busy_c%0d", c), 32'(rd_if.rd_busy_h), 32'(c <= LAT));
      chk($sformatf("t1_done_c%0d", c), 32'(rd_if.rd_done_h), 32'(c == LAT));
      chk($sformatf("t1_diag_c%0d", c), 32'(diag_now()), (c <= LAT - 1) ? 32'd5 : 32'd0);
      if (c == LAT) chk("t1_data_at_done", 32'(rd_if.rd_data_h), 32'h2A5A5);
      step();
    end
    chk("t1_data_held", 32'(rd_if.rd_data_h), 32'h2A5A5);

    // Request while busy is dropped and does not disturb the latched code
    rd_if.rd_func_h  = 3'b010;
    rd_if.ebus_d_e_h = 18'h01234;
    rd_if.rd_req_h   = 1'b1;
    sb_q.push_back('{18'h01234, 1'b0});
    step();
    rd_if.rd_req_h = 1'b0;
    step(); step();
    rd_if.rd_req_h  = 1'b1;
    rd_if.rd_func_h = 3'b111;
    step();
    rd_if.rd_req_h = 1'b0;
    chk("t2_diag_kept", 32'(diag_now()), 32'd2);
    wait_idle(2 * LAT, "t2_idle");
    for (int c = 0; c < 2 * LAT; c++) step();
    chk("t2_not_queued", 32'(rd_if.rd_busy_h), 32'd0);

    // Request held high: back-to-back reads with one idle cycle between
    rd_if.rd_func_h  = 3'b011;
    rd_if.ebus_d_e_h = 18'h3C3C3;
    n_acc = 0;
    for (int k = 0; k * (LAT + 1) <= 19; k++) begin
      n_acc++;
      sb_q.push_back('{18'h3C3C3, 1'b0});
    end
    rd_if.rd_req_h = 1'b1;
    step();
    for (int c = 1; c <= n_acc * (LAT + 1) + 3; c++) begin
      if (c == 20) rd_if.rd_req_h = 1'b0;
      chk($sformatf("t3_done_c%0d", c), 32'(rd_if.rd_done_h),
          32'((c % (LAT + 1) == LAT) && (c / (LAT + 1) < n_acc)));
      chk($sformatf("t3_busy_c%0d", c), 32'(rd_if.rd_busy_h),
          32'((c % (LAT + 1) != 0) && ((c - 1) / (LAT + 1) < n_acc)));
      step();
    end
    rd_if.rd_req_h = 1'b0;

    // Reset in the middle of the strobe
    rd_if.rd_func_h  = 3'b110;
    rd_if.ebus_d_e_h = 18'h15555;
    rd_if.rd_req_h   = 1'b1;
    step();
    rd_if.rd_req_h = 1'b0;
    step(); step(); step();
    chk("t4_strobe_before", 32'(rd_if.ctl3_diag_rd_func_11x_l), 32'd0);
    mr_reset_l = 1'b0;
    #1;
    chk("t4_strobe_async", 32'(rd_if.ctl3_diag_rd_func_11x_l), 32'd1);
    chk("t4_data_cleared", 32'(rd_if.rd_data_h), 32'd0);
    chk("t4_busy_cleared", 32'(rd_if.rd_busy_h), 32'd0);
    chk("t4_diag_cleared", 32'(diag_now()), 32'd0);
    step();
    chk("t4_no_done", 32'(rd_if.rd_done_h), 32'd0);
    @(negedge clk_mtr_h);
    mr_reset_l = 1'b1;
    for (int c = 0; c < LAT + 2; c++) step();
    rd_if.rd_func_h  = 3'b001;
    rd_if.ebus_d_e_h = 18'h0ABCD;
    rd_if.rd_req_h   = 1'b1;
    sb_q.push_back('{18'h0ABCD, 1'b0});
    step();
    rd_if.rd_req_h = 1'b0;
    wait_idle(LAT + 4, "t4_after_idle");
    chk("t4_after_data", 32'(rd_if.rd_data_h), 32'h0ABCD);

    // Vector table
    for (int i = 0; i < 5; i++) begin
      rd_if.rd_func_h  = vecs[i].func;
      rd_if.ebus_d_e_h = vecs[i].ebus;
      rd_if.rd_req_h   = 1'b1;
      sb_q.push_back('{vecs[i].exp_data, 1'b0});
      step();
      rd_if.rd_req_h  = 1'b0;
      rd_if.rd_func_h = ~vecs[i].func;
      for (int c = 0; c < S; c++) step();
      chk($sformatf("vec%0d_diag", i), 32'(diag_now()), 32'(vecs[i].exp_diag));
      chk($sformatf("vec%0d_strobe", i), 32'(rd_if.ctl3_diag_rd_func_11x_l), 32'd0);
      wait_idle(LAT + 4, $sformatf("vec%0d_idle", i));
      chk($sformatf("vec%0d_data", i), 32'(rd_if.rd_data_h), 32'(vecs[i].exp_data));
      step();
    end

`ifdef MTR_RD_STABLE_EN
    // One mismatch, then a stable pair
    sb_q.push_back('{18'h01000, 1'b0});
    run_pat(18'h00FFF, 18'h01000, 1'b0, done_c, n_strobe);
    chk("t5_strobes", 32'(n_strobe), 32'd3);
    chk("t5_done_cycle", 32'(done_c), 32'(1 + S + 3 * T + 2));
    chk("t5_data", 32'(rd_if.rd_data_h), 32'h01000);

    // Never stable: retries exhausted
    sb_q.push_back('{18'h3FFFF, 1'b1});
    run_pat(18'h00000, 18'h3FFFF, 1'b1, done_c, n_strobe);
    chk("t6_strobes", 32'(n_strobe), 32'd4);
    chk("t6_done_cycle", 32'(done_c), 32'(1 + S + 4 * T + 3));
    chk("t6_data", 32'(rd_if.rd_data_h), 32'h3FFFF);
    chk("t6_err_cleared", 32'(rd_if.rd_err_h), 32'd0);
`else
    done_c   = 0;
    n_strobe = 0;
`endif

    step(); step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
